// File: rtl/axi_rd_gen.sv
// AXI3 read-burst generator: issues NUM_BURSTS INCR reads starting at BASE_ADDR and
// checks every returned word against its own byte address, counting bad beats.
module axi_rd_gen #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          NUM_BURSTS = 8,
    parameter int          BURST_LEN  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] err_count,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [7:0]  LAST_IDX    = 8'(NUM_BURSTS - 1);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  idx_r;
    logic [7:0]  beat_r;
    logic [31:0] addr_r;
    logic [7:0]  arlen_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic [15:0] err_cnt_r;
    logic [31:0] exp_data_s;
    logic        run_start_s;
    logic        ar_hs_s;
    logic        beat_acc_s;
    logic        beat_err_s;
    logic        burst_end_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic beat_bad(
        input logic [3:0]  got_id,
        input logic [3:0]  want_id,
        input logic [1:0]  resp,
        input logic [31:0] got_data,
        input logic [31:0] want_data,
        input logic        last,
        input logic        is_last_beat
    );
        return (got_id != want_id) || (resp != 2'b00) ||
               (got_data != want_data) || (last != is_last_beat);
    endfunction

    // Handshake decode, beat checking and next-state selection.
    always_comb begin
        run_start_s = (state_r == IDLE) && start;
        ar_hs_s     = (state_r == AR) && arvalid_r && arready;
        beat_acc_s  = (state_r == R) && rready_r && rvalid;
        exp_data_s  = addr_r + {22'd0, beat_r, 2'b00};
        beat_err_s  = beat_acc_s && beat_bad(rid, idx_r[3:0], rresp, rdata, exp_data_s,
                                             rlast, (beat_r == LAST_BEAT));
        burst_end_s = beat_acc_s && rlast;
        state_nx_s  = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = AR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            AR: begin
                if (ar_hs_s) begin
                    state_nx_s = R;
                end else begin
                    state_nx_s = AR;
                end
            end
            R: begin
                if (burst_end_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_nx_s = FIN;
                    end else begin
                        state_nx_s = AR;
                    end
                end else begin
                    state_nx_s = R;
                end
            end
            FIN:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register; handshake and status outputs are registered copies of the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            arvalid_r <= (state_nx_s == AR);
            rready_r  <= (state_nx_s == R);
            busy_r    <= (state_nx_s != IDLE);
            done_r    <= (state_nx_s == FIN);
        end
    end

    // Burst index, burst address and beat counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_r   <= 8'd0;
            addr_r  <= 32'd0;
            arlen_r <= 8'd0;
            beat_r  <= 8'd0;
        end else if (run_start_s) begin
            idx_r   <= 8'd0;
            addr_r  <= BASE_ADDR;
            arlen_r <= LAST_BEAT;
            beat_r  <= 8'd0;
        end else if (ar_hs_s) begin
            beat_r  <= 8'd0;
        end else if (beat_acc_s) begin
            beat_r <= sat_inc8(beat_r);
            // Address advances only when another burst follows, so it stays valid through FIN.
            if (rlast && (idx_r != LAST_IDX)) begin
                idx_r  <= idx_r + 8'd1;
                addr_r <= addr_r + BURST_BYTES;
            end else begin
                idx_r  <= idx_r;
                addr_r <= addr_r;
            end
        end else begin
            idx_r  <= idx_r;
            addr_r <= addr_r;
            beat_r <= beat_r;
        end
    end

    // Sticky error flag and saturating errored-beat counter, cleared by a new run.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_r     <= 1'b0;
            err_cnt_r <= 16'd0;
        end else if (run_start_s) begin
            err_r     <= 1'b0;
            err_cnt_r <= 16'd0;
        end else if (beat_err_s) begin
            err_r     <= 1'b1;
            err_cnt_r <= sat_inc16(err_cnt_r);
        end else begin
            err_r     <= err_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_count = err_cnt_r;
    assign arid      = idx_r[3:0];
    assign araddr    = addr_r;
    assign arlen     = arlen_r;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign arvalid   = arvalid_r;
    assign rready    = rready_r;

endmodule

// File: doc/axi_rd_gen.md
AXI_RD_GEN -- requirements
Module: axi_rd_gen

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first burst; SHALL be 4-byte aligned.
REQ-002 Parameter NUM_BURSTS, default 8: number of read bursts per run, range 1..256.
REQ-003 Parameter BURST_LEN, default 4: beats per burst, range 1..256; arlen = BURST_LEN-1.
REQ-004 Port clk  in  1: single clock; all logic is on its rising edge.
REQ-005 Port resetn  in  1: reset, asynchronous assert, active-low.
REQ-006 Port start  in  1: a one-cycle pulse begins a run.
REQ-007 Port busy  out  1: high while a run is in progress.
REQ-008 Port done  out  1: one-cycle pulse when a run completes.
REQ-009 Port err  out  1: sticky error flag.
REQ-010 Port err_count  out  16: count of errored beats, saturating.
REQ-011 Ports arid out 4; araddr out 32; arlen out 8; arsize out 3; arburst out 2; arlock out 2; arcache out 4; arprot out 3; arvalid out 1; arready in 1: AXI3 read-address channel, master side.
REQ-012 Ports rid in 4; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1: AXI3 read-data channel, master side.

Function
REQ-013 The FSM SHALL have four states: IDLE, AR, R and FIN.
REQ-014 IDLE: on start=1, go to AR, set burst index to 0 and clear err and err_count; start SHALL be ignored in any other state.
REQ-015 AR: arvalid=1; araddr = BASE_ADDR + idx*BURST_LEN*4, modulo 2^32; arid = idx[3:0]; arlen = BURST_LEN-1.
REQ-016 AR constants SHALL be arsize=3'b010, arburst=2'b01 (INCR), arlock=0, arcache=0 and arprot=0.
REQ-017 All AR signals SHALL stay stable while arvalid=1 and arready=0; on arvalid&arready, go to R the next cycle with beat counter 0.
REQ-018 R: rready=1; a beat is accepted on rvalid&rready.
REQ-019 Expected data for beat k SHALL be araddr+4*k (32-bit wrap).
REQ-020 A beat SHALL be errored if any of the following holds: rid != arid; rresp != 2'b00; rdata != expected; rlast=1 with k != BURST_LEN-1; rlast=0 with k == BURST_LEN-1.
REQ-021 Each errored beat SHALL increment err_count by exactly 1 (saturating at 16'hFFFF) and set err.
REQ-022 The beat counter SHALL be 8 bits, increment per accepted beat, and saturate at 255.
REQ-023 A burst SHALL end only on an accepted beat with rlast=1; extra beats after BURST_LEN-1 keep counting as errors.
REQ-024 At burst end: if idx == NUM_BURSTS-1, go to FIN; otherwise idx increments and the FSM goes to AR; at most one outstanding read.
REQ-025 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-026 busy SHALL be 1 in AR, R and FIN, and 0 in IDLE.
REQ-027 arvalid and rready SHALL be registered outputs, with no combinational path from any input to any output.
REQ-028 Beats with rvalid=1 in IDLE or AR SHALL be ignored (rready=0); err and err_count SHALL hold their values in IDLE until the next start.

Reset
REQ-029 On resetn=0, asynchronously: state=IDLE, arvalid=0, rready=0, busy=0, done=0, err=0, err_count=0, idx=0, beat counter=0.
REQ-030 The AR payload outputs (araddr, arid, arlen) SHALL also reset to 0.
REQ-031 Reset asserted mid-burst SHALL abandon the run; after release the block waits in IDLE for start.

Verification
REQ-032 Defaults, bridge+SRAM preloaded word[i]=4*i, start pulse -> 8 AR handshakes (araddr 0x00,0x10,...,0x70; arid 0..7; arlen=3); 32 beats; done pulse; err=0; err_count=0.
REQ-033 arready held low 5 cycles on burst 0 -> arvalid=1 and araddr=0 stable for all 5 cycles; single handshake; run completes normally.
REQ-034 Word at 0x24 corrupted to 0xDEADBEEF -> err=1, err_count=1 after done.
REQ-035 Slave drives rlast on beat 2 of burst 1 (BURST_LEN=4) -> beat 2 counted errored; burst 1 ends; burst 2 issued at 0x20; err_count=1.
REQ-036 rresp=2'b10 on every beat -> err_count=32 at done; a second start -> counters clear to 0 first.
REQ-037 resetn=0 for 1 cycle during burst 3 R phase -> all outputs at reset values; no AR issued until a new start; new run begins at araddr=BASE_ADDR with arid=0.
